// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache to physical-memory arbiter.
// Default widths match the cache datapaths that sit on either side.
package cache_arbiter_types;

  localparam int ADDR_W_DFLT = 32;
  localparam int LINE_W_DFLT = 256;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SERVE_I = 2'd1,
    S_SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_arbiter_mux.sv
// Combinational steering of the memory port and completion routing
// for whichever cache currently holds the grant.
module cache_arbiter_mux
  import cache_arbiter_types::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int LINE_W = LINE_W_DFLT
) (
  input  logic              active,
  input  grant_t            grant,
  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  input  logic              pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  output logic              i_pmem_resp,
  output logic              d_pmem_resp
);

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    if (active) begin
      case (grant)
        GRANT_I: begin
          pmem_read    = 1'b1;
          pmem_address = i_pmem_address;
          i_pmem_resp  = pmem_resp;
        end
        GRANT_D: begin
          // A simultaneous read+write is illegal; the writeback takes priority.
          pmem_read    = d_pmem_read & ~d_pmem_write;
          pmem_write   = d_pmem_write;
          pmem_address = d_pmem_address;
          pmem_wdata   = d_pmem_wdata;
          d_pmem_resp  = pmem_resp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical memory between the I-cache and
// D-cache; a grant is held from the first strobe until the memory responds.
module cache_arbiter
  import cache_arbiter_types::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int LINE_W = LINE_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state, next_state;
  grant_t     last_grant;
  logic       grant_active;
  grant_t     grant_sel;
  logic       i_req, d_req;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // Returned lines go to both caches; only the routed resp qualifies them.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= GRANT_D;
    end else begin
      state <= next_state;
      if (pmem_resp && state == S_SERVE_I) last_grant <= GRANT_I;
      if (pmem_resp && state == S_SERVE_D) last_grant <= GRANT_D;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (i_req && d_req)
          next_state = (last_grant == GRANT_D) ? S_SERVE_I : S_SERVE_D;
        else if (i_req)
          next_state = S_SERVE_I;
        else if (d_req)
          next_state = S_SERVE_D;
      end
      S_SERVE_I: if (pmem_resp) next_state = S_IDLE;
      S_SERVE_D: if (pmem_resp) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_comb begin
    grant_active = (state == S_SERVE_I) || (state == S_SERVE_D);
    grant_sel    = (state == S_SERVE_D) ? GRANT_D : GRANT_I;
  end

  cache_arbiter_mux #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) u_mux (
    .active         (grant_active),
    .grant          (grant_sel),
    .i_pmem_address (i_pmem_address),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .pmem_resp      (pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_resp    (d_pmem_resp)
  );

  // A cache must hold its request for the whole grant.
  a_i_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state == S_SERVE_I) |-> i_req);
  a_d_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state == S_SERVE_D) |-> d_req);
  a_d_rw_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: ties, evict-then-read, spurious resp, reset abort.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int checks   = 0;
  int failures = 0;

  localparam logic [255:0] LINE_A5 = {32{8'hA5}};
  localparam logic [255:0] LINE_5A = {32{8'h5A}};
  localparam logic [255:0] LINE_R1 = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] WB_LINE = {8{32'h1234_5678}};
  localparam logic [255:0] WB_LINE2 = {8{32'hCAFE_F00D}};

  cache_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe/address snapshot taken on the falling edge of the current cycle.
  task automatic check_bus(input string tag, input logic rd, input logic wr, input logic [31:0] addr);
    @(negedge clk);
    check({tag, "_rd"}, 256'(pmem_read), 256'(rd));
    check({tag, "_wr"}, 256'(pmem_write), 256'(wr));
    check({tag, "_addr"}, 256'(pmem_address), 256'(addr));
  endtask

  initial begin
    rst_n = 1'b0;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rd", 256'(pmem_read), 256'(0));
    check("rst_wr", 256'(pmem_write), 256'(0));
    check("rst_addr", 256'(pmem_address), 256'(0));
    check("rst_wdata", pmem_wdata, 256'(0));
    check("rst_iresp", 256'(i_pmem_resp), 256'(0));
    check("rst_dresp", 256'(d_pmem_resp), 256'(0));
    rst_n = 1'b1;
    tick();

    // First tie after reset goes to I
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0100;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0200;
    check_bus("tie0_idle", 1'b0, 1'b0, 32'h0);
    tick();
    check_bus("tie0_grant_i", 1'b1, 1'b0, 32'h0000_0100);
    tick();
    pmem_resp = 1'b1; pmem_rdata = LINE_R1;
    @(negedge clk);
    check("tie0_iresp", 256'(i_pmem_resp), 256'(1));
    check("tie0_dresp", 256'(d_pmem_resp), 256'(0));
    check("tie0_irdata", i_pmem_rdata, LINE_R1);
    tick();
    // I re-requests immediately; last_grant=I so the tie goes to D
    pmem_resp = 1'b0; i_pmem_address = 32'h0000_0300;
    check_bus("tie1_idle", 1'b0, 1'b0, 32'h0);
    tick();
    pmem_resp = 1'b1; pmem_rdata = LINE_5A;
    check_bus("tie1_grant_d", 1'b1, 1'b0, 32'h0000_0200);
    check("tie1_dresp", 256'(d_pmem_resp), 256'(1));
    check("tie1_iresp", 256'(i_pmem_resp), 256'(0));
    check("tie1_drdata", d_pmem_rdata, LINE_5A);
    tick();
    // D re-requests; last_grant=D so the tie goes to I
    pmem_resp = 1'b0; d_pmem_address = 32'h0000_0400;
    check_bus("tie2_idle", 1'b0, 1'b0, 32'h0);
    tick();
    pmem_resp = 1'b1;
    check_bus("tie2_grant_i", 1'b1, 1'b0, 32'h0000_0300);
    check("tie2_iresp", 256'(i_pmem_resp), 256'(1));
    tick();
    pmem_resp = 1'b0; i_pmem_read = 1'b0;
    check_bus("tie3_idle", 1'b0, 1'b0, 32'h0);
    tick();
    pmem_resp = 1'b1;
    check_bus("tie3_grant_d", 1'b1, 1'b0, 32'h0000_0400);
    check("tie3_dresp", 256'(d_pmem_resp), 256'(1));
    tick();
    pmem_resp = 1'b0; d_pmem_read = 1'b0;
    check_bus("tie_done", 1'b0, 1'b0, 32'h0);
    tick();

    // Spurious resp while idle
    pmem_resp = 1'b1;
    @(negedge clk);
    check("spur_iresp", 256'(i_pmem_resp), 256'(0));
    check("spur_dresp", 256'(d_pmem_resp), 256'(0));
    check("spur_rd", 256'(pmem_read), 256'(0));
    tick();
    pmem_resp = 1'b0;
    check_bus("spur_after", 1'b0, 1'b0, 32'h0);
    tick();

    // I-only read, memory responds after four cycles
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1240;
    check_bus("iread_n0", 1'b0, 1'b0, 32'h0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      check_bus("iread_wait", 1'b1, 1'b0, 32'h0000_1240);
      check("iread_wait_iresp", 256'(i_pmem_resp), 256'(0));
      tick();
    end
    pmem_resp = 1'b1; pmem_rdata = LINE_A5;
    check_bus("iread_n4", 1'b1, 1'b0, 32'h0000_1240);
    check("iread_iresp", 256'(i_pmem_resp), 256'(1));
    check("iread_irdata", i_pmem_rdata, LINE_A5);
    check("iread_dresp", 256'(d_pmem_resp), 256'(0));
    tick();
    i_pmem_read = 1'b0; pmem_resp = 1'b0;
    check_bus("iread_done", 1'b0, 1'b0, 32'h0);
    check("iread_done_iresp", 256'(i_pmem_resp), 256'(0));
    tick();

    // D evict then read: two separate grants with one idle cycle between
    d_pmem_write = 1'b1; d_pmem_address = 32'h8000_0040; d_pmem_wdata = WB_LINE;
    check_bus("evict_idle", 1'b0, 1'b0, 32'h0);
    tick();
    check_bus("evict_strobe", 1'b0, 1'b1, 32'h8000_0040);
    check("evict_wdata", pmem_wdata, WB_LINE);
    tick();
    pmem_resp = 1'b1;
    @(negedge clk);
    check("evict_dresp", 256'(d_pmem_resp), 256'(1));
    check("evict_iresp", 256'(i_pmem_resp), 256'(0));
    tick();
    pmem_resp = 1'b0; d_pmem_write = 1'b0;
    d_pmem_read = 1'b1; d_pmem_address = 32'h8000_0080;
    check_bus("evict_gap", 1'b0, 1'b0, 32'h0);
    check("evict_gap_dresp", 256'(d_pmem_resp), 256'(0));
    tick();
    pmem_resp = 1'b1; pmem_rdata = LINE_5A;
    check_bus("fill_strobe", 1'b1, 1'b0, 32'h8000_0080);
    check("fill_dresp", 256'(d_pmem_resp), 256'(1));
    check("fill_drdata", d_pmem_rdata, LINE_5A);
    tick();
    pmem_resp = 1'b0; d_pmem_read = 1'b0;
    check_bus("fill_done", 1'b0, 1'b0, 32'h0);
    tick();

    // Reset in the middle of a writeback grant
    d_pmem_write = 1'b1; d_pmem_address = 32'h8000_0100; d_pmem_wdata = WB_LINE2;
    tick();
    check_bus("abort_pre", 1'b0, 1'b1, 32'h8000_0100);
    #2;
    rst_n = 1'b0; d_pmem_write = 1'b0;
    #1;
    check("abort_wr", 256'(pmem_write), 256'(0));
    check("abort_addr", 256'(pmem_address), 256'(0));
    check("abort_wdata", pmem_wdata, 256'(0));
    tick();
    rst_n = 1'b1;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_2000;
    check_bus("post_rst_idle", 1'b0, 1'b0, 32'h0);
    tick();
    pmem_resp = 1'b1; pmem_rdata = LINE_A5;
    check_bus("post_rst_grant", 1'b1, 1'b0, 32'h0000_2000);
    check("post_rst_iresp", 256'(i_pmem_resp), 256'(1));
    tick();
    pmem_resp = 1'b0; i_pmem_read = 1'b0;
    check_bus("post_rst_done", 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Sits directly downstream of the instruction-cache and data-cache controllers' physical-memory ports and upstream of the single physical memory.
- Grants the shared memory to one cache at a time and holds the grant until the memory responds.
- Routes the response and read line back to the granted cache only.
- Round-robin fairness on simultaneous requests; the data cache's evict-then-read sequence is served as two separate grants.

Parameters:
- ADDR_W, 32, physical address width.
- LINE_W, 256, cache line width in bits.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_pmem_read  in  1  I-cache line read request; level, held until i_pmem_resp.
- i_pmem_address  in  ADDR_W  I-cache line address; stable while request held.
- i_pmem_rdata  out  LINE_W  line returned to I-cache.
- i_pmem_resp  out  1  one-cycle completion pulse to I-cache.
- d_pmem_read  in  1  D-cache line read request; level.
- d_pmem_write  in  1  D-cache writeback request; level.
- d_pmem_address  in  ADDR_W  D-cache line address.
- d_pmem_wdata  in  LINE_W  D-cache writeback line.
- d_pmem_rdata  out  LINE_W  line returned to D-cache.
- d_pmem_resp  out  1  one-cycle completion pulse to D-cache.
- pmem_read  out  1  memory read strobe; level.
- pmem_write  out  1  memory write strobe; level.
- pmem_address  out  ADDR_W  memory address.
- pmem_wdata  out  LINE_W  memory write line.
- pmem_rdata  in  LINE_W  memory read line.
- pmem_resp  in  1  memory completion, single-cycle pulse.

Behaviour:
- States: S_IDLE, S_SERVE_I, S_SERVE_D. Also a registered last_grant flag (I or D).
- Reset (rst_n low, asynchronous): state=S_IDLE, last_grant=D.
- Outputs during reset: pmem_read=pmem_write=0, i_pmem_resp=d_pmem_resp=0, pmem_address=0, pmem_wdata=0.
- Reset mid-transaction drops the strobes immediately. Memory must tolerate the abort.
- S_IDLE: drives no strobes and no resp.
  - Only I requesting -> S_SERVE_I.
  - Only D requesting (read or write) -> S_SERVE_D.
  - Both requesting -> grant the side not equal to last_grant. The first tie after reset goes to I.
  - Neither requesting -> stay.
- S_SERVE_I:
  - pmem_read=1, pmem_address=i_pmem_address, pmem_write=0, pmem_wdata=0.
  - i_pmem_resp=pmem_resp.
  - On pmem_resp: -> S_IDLE, last_grant<=I.
- S_SERVE_D:
  - pmem_read=d_pmem_read & ~d_pmem_write.
  - pmem_write=d_pmem_write.
  - pmem_address=d_pmem_address, pmem_wdata=d_pmem_wdata.
  - d_pmem_resp=pmem_resp.
  - On pmem_resp: -> S_IDLE, last_grant<=D.
- Non-granted side's resp is always 0. rdata outputs are both continuously driven from pmem_rdata; only resp qualifies them.
- Latency:
  - Request first seen high in S_IDLE at cycle N -> strobe at N+1.
  - pmem_resp at cycle M -> resp to the cache at M (combinational pass).
  - S_IDLE at M+1; the next grant's strobe at M+2.
  - This means a back-to-back D evict->read gives the waiting I request a chance at M+1 if I lost the previous tie.
- Requests are sampled only in S_IDLE. Deassertion during a grant is illegal: the arbiter stays in the grant until pmem_resp, and a simulation assertion fires.
- d_pmem_read and d_pmem_write both high is illegal: write wins, and an assertion fires.
- pmem_resp in S_IDLE is ignored: no resp forwarded, no state change.

Decomposition:
- Package cache_arbiter_types:
  - arb_state_t enum (S_IDLE, S_SERVE_I, S_SERVE_D).
  - grant_t enum (GRANT_I, GRANT_D).
  - Default ADDR_W/LINE_W constants shared with the cache datapaths.
- One natural sub-module, cache_arbiter_mux: purely combinational. Selects address/wdata/strobes and resp routing from grant_t; FSM and last_grant stay in cache_arbiter.

Test Plan:
- Reset mid-grant: assert rst_n=0 while S_SERVE_D with pmem_write=1 -> pmem_write falls same cycle without a clock edge; after release, I-only request -> pmem_read at the following edge.
- I-only read: i_pmem_read=1, addr 0x0000_1240 at N; pmem_resp at N+4 with rdata 0xA5..A5 -> pmem_read=1, pmem_address=0x0000_1240 from N+1 to N+4; i_pmem_resp=1 only at N+4 with i_pmem_rdata=0xA5..A5; d_pmem_resp stays 0.
- D evict then read: d_pmem_write=1 addr 0x8000_0040, wdata 0x1234..; resp; then d_pmem_read=1 addr 0x8000_0080 -> pmem_write with correct wdata, one S_IDLE cycle, then pmem_read at 0x8000_0080; two d_pmem_resp pulses.
- Simultaneous after reset: i and d both raise at N -> I granted first; D strobe begins 2 cycles after I's resp; next simultaneous tie with last_grant=D goes to I, after an I win it goes to D.
- Spurious pmem_resp in S_IDLE -> i_pmem_resp=d_pmem_resp=0, state remains S_IDLE.
